// File: rtl/mem_responder.sv
// Wait-state memory responder: single request/response handshake over a word array with byte/half/word lanes.
// Optional build macro MEM_RESP_ALIGN_CHECK_EN rejects misaligned halfword/word accesses.
module mem_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_STATES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [3:0] CNT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic            we_p0;
  logic [AW+1:0]   addr_p0;
  logic [2:0]      funct3_p0;
  logic [31:0]     wdata_p0;
  logic [31:0]     rdata_p1;
  logic            err_p1;
  logic [31:0]     mem [DEPTH_WORDS];

  logic            accept, enter_resp, acc_idle;
  logic            acc_we, acc_err, misalign, wr_en;
  logic [AW+1:0]   acc_addr;
  logic [2:0]      acc_funct3;
  logic [31:0]     acc_wdata, rd_word;
  logic [AW-1:0]   idx;
  logic [1:0]      off;
  logic            unused_addr_hi;

  function automatic logic illegal_f3(input logic we, input logic [2:0] f3);
    return (f3 == 3'b011) || (f3[2:1] == 2'b11) || (we && f3[2]);
  endfunction

  function automatic logic [31:0] load_ext(input logic [31:0] word, input logic [2:0] f3,
                                           input logic [1:0] lane);
    logic signed [7:0]  b;
    logic signed [15:0] h;
    logic signed [31:0] r;
    b = word[{lane, 3'b000} +: 8];
    h = lane[1] ? word[31:16] : word[15:0];
    case (f3)
      3'b000:  r = b;
      3'b001:  r = h;
      3'b010:  r = word;
      3'b100:  r = {24'd0, b};
      3'b101:  r = {16'd0, h};
      default: r = '0;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] store_merge(input logic [31:0] old, input logic [31:0] wd,
                                              input logic [1:0] size, input logic [1:0] lane);
    logic [31:0] w;
    w = old;
    case (size)
      2'b00: w[{lane, 3'b000} +: 8] = wd[7:0];
      2'b01: begin
        if (lane[1]) w[31:16] = wd[15:0];
        else         w[15:0]  = wd[15:0];
      end
      default: w = wd;
    endcase
    return w;
  endfunction

  assign unused_addr_hi = ^req_addr[31:AW+2];

  assign req_ready  = (state_q == IDLE);
  assign rsp_valid  = (state_q == RESP);
  assign rsp_rdata  = rdata_p1;
  assign rsp_err    = err_p1;
  assign accept     = req_valid && (state_q == IDLE);
  assign enter_resp = (accept && (WAIT_STATES == 0)) || ((state_q == WAIT) && (cnt_q == 4'd0));

  // With zero wait states the access is evaluated straight from the request inputs.
  assign acc_idle   = (state_q == IDLE);
  assign acc_we     = acc_idle ? req_we               : we_p0;
  assign acc_addr   = acc_idle ? req_addr[AW+1:0]     : addr_p0;
  assign acc_funct3 = acc_idle ? req_funct3           : funct3_p0;
  assign acc_wdata  = acc_idle ? req_wdata            : wdata_p0;
  assign idx        = acc_addr[AW+1:2];
  assign off        = acc_addr[1:0];
  assign rd_word    = mem[idx];

`ifdef MEM_RESP_ALIGN_CHECK_EN
  assign misalign = ((acc_funct3[1:0] == 2'b01) && off[0]) ||
                    ((acc_funct3[1:0] == 2'b10) && (off != 2'b00));
`else
  assign misalign = 1'b0;
`endif

  assign acc_err = illegal_f3(acc_we, acc_funct3) || misalign;
  assign wr_en   = enter_resp && acc_we && !acc_err;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          cnt_d   = CNT_LOAD;
          state_d = (WAIT_STATES == 0) ? RESP : WAIT;
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) state_d = RESP;
        else               cnt_d   = cnt_q - 4'd1;
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Stage p0: request capture at accept
  always_ff @(posedge clk) begin
    if (accept) begin
      we_p0     <= req_we;
      addr_p0   <= req_addr[AW+1:0];
      funct3_p0 <= req_funct3;
      wdata_p0  <= req_wdata;
    end
  end

  // Stage p1: storage access and response registered on the edge entering RESP
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      cnt_q    <= 4'd0;
      rdata_p1 <= 32'd0;
      err_p1   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (enter_resp) begin
        err_p1   <= acc_err;
        rdata_p1 <= (acc_err || acc_we) ? 32'd0 : load_ext(rd_word, acc_funct3, off);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[idx] <= store_merge(rd_word, acc_wdata, acc_funct3[1:0], off);
  end

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: directed table, corner sequences, randomized ops vs a byte-array model.
module tb_mem_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_we, rsp_ready, sel;
  logic [31:0] req_addr, req_wdata;
  logic [2:0]  req_funct3;

  logic        rv_a, ready_a, valid_a, err_a;
  logic        rv_b, ready_b, valid_b, err_b;
  logic [31:0] rdata_a, rdata_b;
  logic        cur_ready, cur_valid, cur_err;
  logic [31:0] cur_rdata;

  int n_pass = 0;
  int n_total = 0;

  logic [7:0] mem_b [1024];

  typedef struct {
    bit          we;
    logic [31:0] addr;
    logic [2:0]  f3;
    logic [31:0] wd;
    logic [31:0] exp_rd;
    bit          exp_err;
  } vec_t;
  vec_t tbl[$];

  always #5 clk = ~clk;

  assign rv_a      = req_valid & ~sel;
  assign rv_b      = req_valid & sel;
  assign cur_ready = sel ? ready_b : ready_a;
  assign cur_valid = sel ? valid_b : valid_a;
  assign cur_err   = sel ? err_b   : err_a;
  assign cur_rdata = sel ? rdata_b : rdata_a;

  mem_responder #(.DEPTH_WORDS(256), .WAIT_STATES(2)) dut (
    .clk(clk), .reset(reset), .req_valid(rv_a), .req_ready(ready_a), .req_we(req_we),
    .req_addr(req_addr), .req_funct3(req_funct3), .req_wdata(req_wdata), .rsp_valid(valid_a),
    .rsp_ready(rsp_ready), .rsp_rdata(rdata_a), .rsp_err(err_a));

  mem_responder #(.DEPTH_WORDS(16), .WAIT_STATES(0)) dut0 (
    .clk(clk), .reset(reset), .req_valid(rv_b), .req_ready(ready_b), .req_we(req_we),
    .req_addr(req_addr), .req_funct3(req_funct3), .req_wdata(req_wdata), .rsp_valid(valid_b),
    .rsp_ready(rsp_ready), .rsp_rdata(rdata_b), .rsp_err(err_b));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %08h, expected %08h", name, act, exp);
  endtask

  function automatic int nbytes(input logic [2:0] f3);
    if (f3[1:0] == 2'b00) return 1;
    if (f3[1:0] == 2'b01) return 2;
    return 4;
  endfunction

  function automatic bit model_err(input bit we, input logic [2:0] f3, input logic [31:0] a);
    bit e;
    e = (f3 == 3) || (f3 == 6) || (f3 == 7) || (we && (f3 == 4 || f3 == 5));
`ifdef MEM_RESP_ALIGN_CHECK_EN
    if ((f3 == 1 || f3 == 5) && a[0]) e = 1;
    if (f3 == 2 && a[1:0] != 2'b00) e = 1;
`else
    if (a[0] && 1'b0) e = 1;
`endif
    return e;
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] a, input logic [2:0] f3);
    int n, base;
    logic [31:0] v;
    n = nbytes(f3);
    base = int'(a[9:0]) / n * n;
    v = 32'd0;
    for (int i = 0; i < n; i++) v = v | (32'(mem_b[base + i]) << (8 * i));
    if (!f3[2] && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8 * n));
    return v;
  endfunction

  task automatic model_store(input logic [31:0] a, input logic [2:0] f3, input logic [31:0] wd);
    int n, base;
    n = nbytes(f3);
    base = int'(a[9:0]) / n * n;
    for (int i = 0; i < n; i++) mem_b[base + i] = wd[8*i +: 8];
  endtask

  task automatic do_req(input bit we, input logic [31:0] a, input logic [2:0] f3,
                        input logic [31:0] wd, input int hold,
                        output logic [31:0] rd, output logic er, output int lat);
    int g;
    @(negedge clk);
    g = 0;
    while (!cur_ready && g < 20) begin @(negedge clk); g++; end
    if (!cur_ready) check("req_ready_wait", 32'(cur_ready), 32'd1);
    req_valid = 1'b1; req_we = we; req_addr = a; req_funct3 = f3; req_wdata = wd;
    @(posedge clk);
    #1 req_valid = 1'b0;
    lat = 0;
    while (lat < 40) begin
      @(negedge clk);
      lat++;
      if (cur_valid) break;
    end
    if (!cur_valid) check("rsp_timeout", 32'(cur_valid), 32'd1);
    rd = cur_rdata;
    er = cur_err;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check("hold_valid", 32'(cur_valid), 32'd1);
      check("hold_rdata", cur_rdata, rd);
      check("hold_err", 32'(cur_err), 32'(er));
      check("hold_req_ready", 32'(cur_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
    @(negedge clk);
    check("post_rsp_ready", 32'(cur_ready), 32'd1);
    check("post_rsp_valid", 32'(cur_valid), 32'd0);
  endtask

  task automatic add(input bit we, input logic [31:0] a, input logic [2:0] f3,
                     input logic [31:0] wd, input logic [31:0] exp_rd, input bit exp_err);
    vec_t v;
    v.we = we; v.addr = a; v.f3 = f3; v.wd = wd; v.exp_rd = exp_rd; v.exp_err = exp_err;
    tbl.push_back(v);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] rd, a, wd, exp_rd;
    logic        er;
    logic [2:0]  f3;
    bit          we, e;
    int          lat, hold;

    reset = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_funct3 = '0;
    req_wdata = '0; rsp_ready = 1'b0; sel = 1'b0;
    for (int i = 0; i < 1024; i++) mem_b[i] = 8'h00;

    repeat (3) @(negedge clk);
    check("rst_req_ready", 32'(ready_a), 32'd1);
    check("rst_rsp_valid", 32'(valid_a), 32'd0);
    check("rst_rsp_rdata", rdata_a, 32'd0);
    check("rst_rsp_err", 32'(err_a), 32'd0);
    check("rst0_req_ready", 32'(ready_b), 32'd1);
    reset = 1'b1;

    add(1, 32'h10,        3'b010, 32'hDEAD_BEEF, 32'h0,         0);
    add(0, 32'h10,        3'b010, 32'h0,         32'hDEAD_BEEF, 0);
    add(1, 32'h13,        3'b000, 32'h1234_5680, 32'h0,         0);
    add(0, 32'h13,        3'b000, 32'h0,         32'hFFFF_FF80, 0);
    add(0, 32'h13,        3'b100, 32'h0,         32'h0000_0080, 0);
    add(0, 32'h10,        3'b010, 32'h0,         32'h80AD_BEEF, 0);
    add(1, 32'h12,        3'b001, 32'h0000_C3D2, 32'h0,         0);
    add(0, 32'h12,        3'b001, 32'h0,         32'hFFFF_C3D2, 0);
    add(0, 32'h12,        3'b101, 32'h0,         32'h0000_C3D2, 0);
    add(0, 32'h10,        3'b000, 32'h0,         32'hFFFF_FFEF, 0);
    add(0, 32'h11,        3'b100, 32'h0,         32'h0000_00BE, 0);
    add(0, 32'h10,        3'b001, 32'h0,         32'hFFFF_BEEF, 0);
    add(0, 32'h410,       3'b010, 32'h0,         32'hC3D2_BEEF, 0);
    add(0, 32'hFFFF_FC10, 3'b010, 32'h0,         32'hC3D2_BEEF, 0);
    add(0, 32'h10,        3'b011, 32'h0,         32'h0,         1);
    add(1, 32'h10,        3'b100, 32'hFFFF_FFFF, 32'h0,         1);
    add(1, 32'h10,        3'b110, 32'hFFFF_FFFF, 32'h0,         1);
    add(0, 32'h10,        3'b111, 32'h0,         32'h0,         1);
    add(0, 32'h10,        3'b010, 32'h0,         32'hC3D2_BEEF, 0);
    add(1, 32'h20,        3'b010, 32'h1122_3344, 32'h0,         0);
    add(0, 32'h22,        3'b101, 32'h0,         32'h0000_1122, 0);
    add(0, 32'h21,        3'b000, 32'h0,         32'h0000_0033, 0);
    add(1, 32'h22,        3'b000, 32'h1234_56F0, 32'h0,         0);
    add(0, 32'h20,        3'b010, 32'h0,         32'h11F0_3344, 0);

    foreach (tbl[i]) begin
      do_req(tbl[i].we, tbl[i].addr, tbl[i].f3, tbl[i].wd, 0, rd, er, lat);
      check($sformatf("tbl%0d_rdata", i), rd, tbl[i].exp_rd);
      check($sformatf("tbl%0d_err", i), 32'(er), 32'(tbl[i].exp_err));
      check($sformatf("tbl%0d_latency", i), 32'(lat), 32'd3);
      if (tbl[i].we && !tbl[i].exp_err) model_store(tbl[i].addr, tbl[i].f3, tbl[i].wd);
    end

    // Response held for 5 cycles with rsp_ready low
    do_req(0, 32'h10, 3'b010, 32'h0, 5, rd, er, lat);
    check("hold_lw_rdata", rd, 32'hC3D2_BEEF);

    // Misaligned halfword store
    do_req(1, 32'h11, 3'b001, 32'h0000_BBBB, 0, rd, er, lat);
`ifdef MEM_RESP_ALIGN_CHECK_EN
    check("sh_misalign_err", 32'(er), 32'd1);
    do_req(0, 32'h10, 3'b010, 32'h0, 0, rd, er, lat);
    check("sh_misalign_nowrite", rd, 32'hC3D2_BEEF);
`else
    check("sh_misalign_err", 32'(er), 32'd0);
    do_req(0, 32'h10, 3'b010, 32'h0, 0, rd, er, lat);
    check("sh_misalign_write", rd, 32'hC3D2_BBBB);
    model_store(32'h11, 3'b001, 32'h0000_BBBB);
`endif

    // Reset asserted during WAIT aborts the store
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h20; req_funct3 = 3'b010;
    req_wdata = 32'h0000_1234;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    check("wait_req_ready", 32'(ready_a), 32'd0);
    reset = 1'b0;
    #2;
    check("rstw_req_ready", 32'(ready_a), 32'd1);
    check("rstw_rsp_valid", 32'(valid_a), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check("rstw_after_valid", 32'(valid_a), 32'd0);
    do_req(0, 32'h20, 3'b010, 32'h0, 0, rd, er, lat);
    check("rstw_lw_prior", rd, 32'h11F0_3344);

    // Reset asserted in RESP drops the response
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h10; req_funct3 = 3'b010;
    @(posedge clk);
    #1 req_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("rstr_valid_before", 32'(valid_a), 32'd1);
    reset = 1'b0;
    #2;
    check("rstr_valid", 32'(valid_a), 32'd0);
    check("rstr_rdata", rdata_a, 32'd0);
    check("rstr_err", 32'(err_a), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    do_req(0, 32'h10, 3'b010, 32'h0, 0, rd, er, lat);
    check("rstr_lw_again", rd, model_load(32'h10, 3'b010));

    // Randomized ops over words 0..15 with random upper address bits
    for (int i = 0; i < 16; i++) begin
      wd = $urandom;
      a = 32'(i * 4);
      do_req(1, a, 3'b010, wd, 0, rd, er, lat);
      model_store(a, 3'b010, wd);
    end
    for (int i = 0; i < 200; i++) begin
      we   = 1'($urandom_range(0, 1));
      f3   = 3'($urandom_range(0, 7));
      a    = ($urandom & 32'hFFFF_FC00) | 32'($urandom_range(0, 63));
      wd   = $urandom;
      hold = $urandom_range(0, 2);
      e    = model_err(we, f3, a);
      exp_rd = (e || we) ? 32'd0 : model_load(a, f3);
      do_req(we, a, f3, wd, hold, rd, er, lat);
      check($sformatf("rnd%0d_rdata a=%08h f3=%0d we=%0d", i, a, f3, we), rd, exp_rd);
      check($sformatf("rnd%0d_err", i), 32'(er), 32'(e));
      check($sformatf("rnd%0d_latency", i), 32'(lat), 32'd3);
      if (we && !e) model_store(a, f3, wd);
    end

    // Zero-wait-state instance, 16 words
    sel = 1'b1;
    do_req(0, 32'h0, 3'b011, 32'h0, 0, rd, er, lat);
    check("ws0_illegal_latency", 32'(lat), 32'd1);
    check("ws0_illegal_err", 32'(er), 32'd1);
    check("ws0_illegal_rdata", rd, 32'd0);
    do_req(1, 32'h4, 3'b010, 32'hCAFE_F00D, 0, rd, er, lat);
    check("ws0_sw_latency", 32'(lat), 32'd1);
    do_req(0, 32'h44, 3'b010, 32'h0, 0, rd, er, lat);
    check("ws0_lw_wrap", rd, 32'hCAFE_F00D);
    check("ws0_lw_err", 32'(er), 32'd0);
    sel = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 The block SHALL have parameter DEPTH_WORDS, default 256, giving the storage size in 32-bit words; it SHALL be a power of two.
REQ-002 The block SHALL have parameter WAIT_STATES, default 2, giving the wait cycles between request accept and response; legal range is 0-15.
REQ-003 The block SHALL use one clock, and reset SHALL be asynchronous and active-low.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 reset  input  1  asynchronous active-low reset.
REQ-006 req_valid  input  1  request present.
REQ-007 req_ready  output  1  responder can accept a request.
REQ-008 req_we  input  1  1 = store, 0 = load.
REQ-009 req_addr  input  32  byte address.
REQ-010 req_funct3  input  3  access size/sign code: 000 b, 001 h, 010 w, 100 bu, 101 hu.
REQ-011 req_wdata  input  32  store data, right-aligned.
REQ-012 rsp_valid  output  1  response present.
REQ-013 rsp_ready  input  1  requester accepts the response.
REQ-014 rsp_rdata  output  32  load result, extended to 32 bits.
REQ-015 rsp_err  output  1  access was rejected.

Function
REQ-016 The FSM SHALL have states IDLE, WAIT and RESP; req_ready SHALL be 1 only in IDLE.
REQ-017 On req_valid&req_ready, the block SHALL latch we, addr, funct3 and wdata, and go to WAIT, or to RESP when WAIT_STATES=0.
REQ-018 WAIT SHALL last exactly WAIT_STATES cycles, counted by a down-counter loaded at accept; the latency from accept edge to rsp_valid=1 SHALL be WAIT_STATES+1 cycles.
REQ-019 Storage access and error evaluation SHALL occur once, on the edge entering RESP; rsp_rdata and rsp_err SHALL be registered on that edge.
REQ-020 In RESP, rsp_valid SHALL be 1 and rsp_rdata/rsp_err SHALL stay stable until rsp_valid&rsp_ready; the block SHALL then return to IDLE on that edge.
REQ-021 The word index SHALL be addr[log2(DEPTH_WORDS)+1:2]; higher address bits SHALL be ignored, so addresses wrap.
REQ-022 Loads SHALL select the byte lane by addr[1:0] and the halfword by addr[1]; funct3 000/001 SHALL sign-extend and 100/101 SHALL zero-extend.
REQ-023 Stores with funct3 000/001/010 SHALL write only the addressed byte, halfword or word lanes; all other lanes SHALL be unchanged.
REQ-024 Illegal funct3 (011, 110, 111, or 100/101 with req_we=1) SHALL give rsp_err=1 and rsp_rdata=0, and no storage write.
REQ-025 Store responses SHALL return rsp_rdata=0.
REQ-026 A new request SHALL NOT be accepted in the cycle the response handshake completes; the earliest accept is the next cycle, in IDLE.

Reset
REQ-027 While reset=0, the FSM SHALL be in IDLE, the counter SHALL be 0, req_ready=1, rsp_valid=0, rsp_rdata=0 and rsp_err=0.
REQ-028 Reset asserted in WAIT SHALL abort the access with no storage write; reset asserted in RESP SHALL drop the response.
REQ-029 Storage contents SHALL NOT be cleared by reset.

Configuration
REQ-030 With macro MEM_RESP_ALIGN_CHECK_EN defined, a halfword access with addr[0]=1 or a word access with addr[1:0]!=0 SHALL give rsp_err=1, rsp_rdata=0 and no write.
REQ-031 Without MEM_RESP_ALIGN_CHECK_EN, a halfword access SHALL use addr[1] only, a word access SHALL ignore addr[1:0], and misalignment SHALL never raise rsp_err.

Verification
REQ-032 Scenario: WAIT_STATES=2; sw 0xDEADBEEF to 0x10, then lw 0x10 -> rsp_valid 3 cycles after each accept, and rsp_rdata=0xDEADBEEF.
REQ-033 Scenario: sb 0x80 to 0x13, then lb 0x13 and lbu 0x13 -> 0xFFFFFF80 and 0x00000080; lw 0x10 -> 0x80ADBEEF.
REQ-034 Scenario: hold rsp_ready=0 for 5 cycles in RESP -> rsp_valid and rsp_rdata stay constant and req_ready=0 throughout.
REQ-035 Scenario: with MEM_RESP_ALIGN_CHECK_EN defined, sh to 0x11 -> rsp_err=1, and a following lw 0x10 returns the word unchanged.
REQ-036 Scenario: assert reset in WAIT of sw 0x1234 to 0x20 -> after reset, req_ready=1, rsp_valid=0, and lw 0x20 returns the prior contents.
REQ-037 Scenario: WAIT_STATES=0 and funct3=011 load -> rsp_valid 1 cycle after accept, with rsp_err=1 and rsp_rdata=0.
